cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter RID_W, default 4, ROB index width (matches ROB_INDEX_BIT).
REQ-002 SHALL have parameter QDEPTH, default 2, per-requester queue depth (power of two, >=2).
REQ-003 SHALL have port clk_in  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rdy_in  input  1  global stall, freeze when low.
REQ-006 SHALL have port flush_in  input  1  misprediction clear from ROB.
REQ-007 SHALL have ports alu_valid_in / lsb_valid_in  input  1  result offered by RS-ALU / LSB.
REQ-008 SHALL have ports alu_rob_id_in / lsb_rob_id_in  input  RID_W  destination ROB entry.
REQ-009 SHALL have ports alu_result_in / lsb_result_in  input  32  result value.
REQ-010 SHALL have ports alu_ready_out / lsb_ready_out  output  1  queue can accept this cycle.
REQ-011 SHALL have port cdb_valid_out  output  1  one-cycle broadcast pulse.
REQ-012 SHALL have ports cdb_rob_id_out  output  RID_W, cdb_result_out  output  32, cdb_src_out  output  1 (0 ALU, 1 LSB).

Function
REQ-013 SHALL hold one FIFO per requester, QDEPTH entries {rob_id, result}, head/tail pointers wrapping modulo QDEPTH, count 0..QDEPTH.
REQ-014 SHALL drive x_ready_out = (count_x < QDEPTH), from registered state only, no combinational path from valid inputs.
REQ-015 SHALL enqueue on an edge where rdy_in=1, flush_in=0, x_valid_in=1, x_ready_out=1; valid while not ready is ignored (requester must hold).
REQ-016 SHALL, per edge with rdy_in=1 and flush_in=0, grant at most one non-empty queue, pop its head, and register it onto cdb_*_out with cdb_valid_out=1.
REQ-017 SHALL deassert cdb_valid_out after any edge with no grant; rob_id/result/src hold last values.
REQ-018 SHALL give minimum latency of one edge from enqueue to broadcast: entry enqueued at edge N appears on cdb_*_out after edge N+1; no same-edge bypass.
REQ-019 SHALL allow enqueue and pop of the same queue on one edge, count unchanged; full queue (ready low) takes no enqueue even if popped that edge.
REQ-020 SHALL, when exactly one queue non-empty, grant it regardless of arbitration history.
REQ-021 SHALL track last_grant (1 bit), updated only on a grant edge.
REQ-022 SHALL, on edge with flush_in=1 (independent of rdy_in), empty both queues, clear cdb_valid_out, drop inputs of that cycle, reset last_grant to 1.
REQ-023 SHALL, with rdy_in=0 and flush_in=0, hold all state and outputs, accept nothing, grant nothing.
REQ-024 SHALL preserve per-requester FIFO order; cross-requester order follows arbitration only.

Reset
REQ-025 SHALL, while rst_n_in=0, force immediately: queues empty, pointers 0, last_grant=1, cdb_valid_out=0, cdb_rob_id_out=0, cdb_result_out=0, cdb_src_out=0, so both ready outputs=1.
REQ-026 SHALL, on reset mid-operation, discard all queued results; first grant possible one edge after first post-reset enqueue.

Configuration
REQ-027 SHALL honour macro CDB_ARB_ROUND_ROBIN_EN: defined -> when both queues non-empty, grant requester != last_grant (alternation, starting ALU after reset/flush).
REQ-028 SHALL, without CDB_ARB_ROUND_ROBIN_EN, use fixed priority: LSB over ALU when both non-empty; last_grant still maintained but unused.

Verification
REQ-029 SHALL cover: reset, ALU offers id=3 res=0x11 at edge 1 -> cdb_valid_out=1, id=3, res=0x11, src=0 after edge 2 only, 1 cycle.
REQ-030 SHALL cover: both offer every cycle (ALU ids 1,2; LSB ids 5,6) with RR_EN -> broadcast order 1,5,2,6; without -> 5,6,1,2.
REQ-031 SHALL cover: ALU offers 3 results back-to-back while LSB streams with priority mode -> alu_ready_out low after 2 queued, third held, none lost or duplicated.
REQ-032 SHALL cover: two entries queued, flush_in=1 with new valid same cycle -> next edge cdb_valid_out=0, both ready=1, nothing ever broadcast from those entries.
REQ-033 SHALL cover: rdy_in=0 for 3 cycles with queued id=7 -> outputs/counts frozen; id=7 broadcast one edge after rdy_in returns 1.
REQ-034 SHALL cover: rst_n_in pulsed low between edges with queue full -> outputs zero immediately, no broadcast after release until new enqueue.

Source files
------------

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-source CDB arbiter with one result FIFO per requester
// Optional macro CDB_ARB_ROUND_ROBIN_EN: alternate grants when both queues hold results.
module cdb_arbiter #(
  parameter int RID_W  = 4,
  parameter int QDEPTH = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             alu_valid_in,
  input  logic [RID_W-1:0] alu_rob_id_in,
  input  logic [31:0]      alu_result_in,
  input  logic             lsb_valid_in,
  input  logic [RID_W-1:0] lsb_rob_id_in,
  input  logic [31:0]      lsb_result_in,
  output logic             alu_ready_out,
  output logic             lsb_ready_out,
  output logic             cdb_valid_out,
  output logic [RID_W-1:0] cdb_rob_id_out,
  output logic [31:0]      cdb_result_out,
  output logic             cdb_src_out
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int EW = RID_W + 32;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  logic [EW-1:0] alu_mem [QDEPTH];
  logic [EW-1:0] lsb_mem [QDEPTH];
  logic [PW-1:0] alu_head, alu_tail, lsb_head, lsb_tail;
  logic [CW-1:0] alu_cnt, lsb_cnt;
  logic          last_grant;
  logic          run, alu_push, lsb_push, alu_pop, lsb_pop;
  logic [EW-1:0] grant_entry;

  // Ready comes from registered counts only, so requesters see no valid->ready path.
  assign alu_ready_out = (alu_cnt < FULL);
  assign lsb_ready_out = (lsb_cnt < FULL);

  assign run      = rdy_in & ~flush_in;
  assign alu_push = run & alu_valid_in & alu_ready_out;
  assign lsb_push = run & lsb_valid_in & lsb_ready_out;

  always_comb begin
    alu_pop = 1'b0;
    lsb_pop = 1'b0;
    if (run) begin
      if ((alu_cnt != '0) && (lsb_cnt != '0)) begin
`ifdef CDB_ARB_ROUND_ROBIN_EN
        // last_grant holds the source of the previous grant; serve the other one.
        alu_pop = last_grant;
        lsb_pop = ~last_grant;
`else
        lsb_pop = 1'b1;
`endif
      end else begin
        alu_pop = (alu_cnt != '0);
        lsb_pop = (lsb_cnt != '0);
      end
    end
  end

  assign grant_entry = lsb_pop ? lsb_mem[lsb_head] : alu_mem[alu_head];

  always_ff @(posedge clk_in) begin
    if (alu_push) alu_mem[alu_tail] <= {alu_rob_id_in, alu_result_in};
    if (lsb_push) lsb_mem[lsb_tail] <= {lsb_rob_id_in, lsb_result_in};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      alu_head       <= '0;
      alu_tail       <= '0;
      alu_cnt        <= '0;
      lsb_head       <= '0;
      lsb_tail       <= '0;
      lsb_cnt        <= '0;
      last_grant     <= 1'b1;
      cdb_valid_out  <= 1'b0;
      cdb_rob_id_out <= '0;
      cdb_result_out <= '0;
      cdb_src_out    <= 1'b0;
    end else if (flush_in) begin
      alu_head      <= '0;
      alu_tail      <= '0;
      alu_cnt       <= '0;
      lsb_head      <= '0;
      lsb_tail      <= '0;
      lsb_cnt       <= '0;
      last_grant    <= 1'b1;
      cdb_valid_out <= 1'b0;
    end else if (rdy_in) begin
      if (alu_push) alu_tail <= alu_tail + PW'(1);
      if (lsb_push) lsb_tail <= lsb_tail + PW'(1);
      if (alu_pop)  alu_head <= alu_head + PW'(1);
      if (lsb_pop)  lsb_head <= lsb_head + PW'(1);
      alu_cnt    <= alu_cnt + CW'(alu_push) - CW'(alu_pop);
      lsb_cnt    <= lsb_cnt + CW'(lsb_push) - CW'(lsb_pop);
      last_grant <= (alu_pop | lsb_pop) ? lsb_pop : last_grant;
      if (alu_pop | lsb_pop) begin
        cdb_valid_out  <= 1'b1;
        cdb_rob_id_out <= grant_entry[EW-1:32];
        cdb_result_out <= grant_entry[31:0];
        cdb_src_out    <= lsb_pop;
      end else begin
        cdb_valid_out <= 1'b0;
      end
    end
  end
endmodule
